matrix_stream_loader: RTL and testbench

- Upstream feeder for the parallel matrix multiplier.
- Accepts one valid/ready stream of 32-bit words: A in row-major order (N*N words), then B in row-major order (N*N words).
- Drives the multiplier's per-element write ports (value, row, column, write strobe) for A and B.
- After the last B word it pulses the multiplier start, waits for its done, reports batch completion, then accepts the next batch.

---
 rtl/matrix_stream_loader_pkg.sv | 17 +
 rtl/matrix_index_counter.sv | 64 ++++++
 rtl/matrix_stream_loader.sv | 160 ++++++++++++++++
 tb/tb_matrix_stream_loader.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_stream_loader_pkg.sv
// Shared types and constants for the matrix stream loader and its index counter.
package matrix_stream_loader_pkg;

  localparam int unsigned WORD_W = 32;

  // Which multiplier port group the current element targets.
  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  typedef enum logic [1:0] {
    StFetch,
    StStrobe,
    StStart,
    StWaitDone
  } state_e;

endpackage

// File: rtl/matrix_index_counter.sv
// Row/column/matrix-select walker over an N x N element grid, row-major, A then B.
module matrix_index_counter
  import matrix_stream_loader_pkg::*;
#(
  parameter int unsigned N    = 10,
  parameter int unsigned NLen = $clog2(N)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            advance_i,
  input  logic            clear_i,
  output logic [NLen-1:0] row_o,
  output logic [NLen-1:0] col_o,
  output logic            sel_o,
  output logic            last_o
);

  localparam logic [NLen-1:0] MaxIdx = NLen'(N - 1);

  logic [NLen-1:0] row_q, row_d;
  logic [NLen-1:0] col_q, col_d;
  logic            sel_q, sel_d;

  assign row_o  = row_q;
  assign col_o  = col_q;
  assign sel_o  = sel_q;
  assign last_o = (row_q == MaxIdx) && (col_q == MaxIdx);

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    sel_d = sel_q;
    if (clear_i) begin
      row_d = '0;
      col_d = '0;
      sel_d = SEL_A;
    end else if (advance_i) begin
      if (col_q == MaxIdx) begin
        col_d = '0;
        if (row_q == MaxIdx) begin
          row_d = '0;
          sel_d = ~sel_q;
        end else begin
          row_d = row_q + 1'b1;
        end
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      row_q <= '0;
      col_q <= '0;
      sel_q <= SEL_A;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
      sel_q <= sel_d;
    end
  end

endmodule

// File: rtl/matrix_stream_loader.sv
// Streams A then B into the multiplier's element write ports, starts it and waits for done.
module matrix_stream_loader
  import matrix_stream_loader_pkg::*;
#(
  parameter int unsigned N     = 10,
  parameter int unsigned N_LEN = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [WORD_W-1:0] a_in,
  output logic [N_LEN-1:0]  a_i,
  output logic [N_LEN-1:0]  a_j,
  output logic              a_we,
  output logic [WORD_W-1:0] b_in,
  output logic [N_LEN-1:0]  b_i,
  output logic [N_LEN-1:0]  b_j,
  output logic              b_we,
  output logic              mm_start,
  input  logic              mm_done,
  output logic              busy,
  output logic              batch_done
);

  state_e state_q, state_d;

  logic [WORD_W-1:0] a_in_q, a_in_d, b_in_q, b_in_d;
  logic [N_LEN-1:0]  a_i_q, a_i_d, a_j_q, a_j_d;
  logic [N_LEN-1:0]  b_i_q, b_i_d, b_j_q, b_j_d;
  logic              a_we_q, a_we_d, b_we_q, b_we_d;
  logic              mm_start_q, mm_start_d;
  logic              busy_q, busy_d;
  logic              batch_done_q, batch_done_d;
  logic              seen_low_q, seen_low_d;

  logic              cnt_advance, cnt_clear;
  logic [N_LEN-1:0]  cnt_row, cnt_col;
  logic              cnt_sel, cnt_last;

  matrix_index_counter #(
    .N    (N),
    .NLen (N_LEN)
  ) u_index_counter (
    .clk_i     (clk),
    .rst_ni    (rst),
    .advance_i (cnt_advance),
    .clear_i   (cnt_clear),
    .row_o     (cnt_row),
    .col_o     (cnt_col),
    .sel_o     (cnt_sel),
    .last_o    (cnt_last)
  );

  assign in_ready   = (state_q == StFetch);
  assign a_in       = a_in_q;
  assign a_i        = a_i_q;
  assign a_j        = a_j_q;
  assign a_we       = a_we_q;
  assign b_in       = b_in_q;
  assign b_i        = b_i_q;
  assign b_j        = b_j_q;
  assign b_we       = b_we_q;
  assign mm_start   = mm_start_q;
  assign busy       = busy_q;
  assign batch_done = batch_done_q;

  always_comb begin
    state_d      = state_q;
    a_in_d       = a_in_q;
    a_i_d        = a_i_q;
    a_j_d        = a_j_q;
    b_in_d       = b_in_q;
    b_i_d        = b_i_q;
    b_j_d        = b_j_q;
    a_we_d       = 1'b0;
    b_we_d       = 1'b0;
    mm_start_d   = 1'b0;
    batch_done_d = 1'b0;
    busy_d       = busy_q;
    seen_low_d   = seen_low_q;
    cnt_advance  = 1'b0;
    cnt_clear    = 1'b0;
    unique case (state_q)
      StFetch: begin
        if (in_valid) begin
          if (cnt_sel == SEL_A) begin
            a_in_d = in_data;
            a_i_d  = cnt_row;
            a_j_d  = cnt_col;
          end else begin
            b_in_d = in_data;
            b_i_d  = cnt_row;
            b_j_d  = cnt_col;
          end
          busy_d  = 1'b1;
          state_d = StStrobe;
        end
      end
      StStrobe: begin
        // Strobe registers a cycle after the data, so data is settled before the rising edge.
        cnt_advance = 1'b1;
        if (cnt_sel == SEL_A) a_we_d = 1'b1;
        else                  b_we_d = 1'b1;
        state_d = (cnt_sel == SEL_B && cnt_last) ? StStart : StFetch;
      end
      StStart: begin
        mm_start_d = 1'b1;
        seen_low_d = 1'b0;
        state_d    = StWaitDone;
      end
      StWaitDone: begin
        // A done level left high from the previous batch is ignored until it drops.
        if (!mm_done) begin
          seen_low_d = 1'b1;
        end else if (seen_low_q) begin
          batch_done_d = 1'b1;
          busy_d       = 1'b0;
          cnt_clear    = 1'b1;
          state_d      = StFetch;
        end
      end
      default: state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StFetch;
      a_in_q       <= '0;
      a_i_q        <= '0;
      a_j_q        <= '0;
      b_in_q       <= '0;
      b_i_q        <= '0;
      b_j_q        <= '0;
      a_we_q       <= 1'b0;
      b_we_q       <= 1'b0;
      mm_start_q   <= 1'b0;
      busy_q       <= 1'b0;
      batch_done_q <= 1'b0;
      seen_low_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      a_in_q       <= a_in_d;
      a_i_q        <= a_i_d;
      a_j_q        <= a_j_d;
      b_in_q       <= b_in_d;
      b_i_q        <= b_i_d;
      b_j_q        <= b_j_d;
      a_we_q       <= a_we_d;
      b_we_q       <= b_we_d;
      mm_start_q   <= mm_start_d;
      busy_q       <= busy_d;
      batch_done_q <= batch_done_d;
      seen_low_q   <= seen_low_d;
    end
  end

endmodule

// File: tb/tb_matrix_stream_loader.sv
// Scoreboard bench: drivers push expected element writes, negedge monitors pop on strobe rise.
module tb_matrix_stream_loader;

  typedef struct packed {
    logic        sel;
    logic [3:0]  i;
    logic [3:0]  j;
    logic [31:0] d;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // N=4 instance
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0, in_ready;
  logic [31:0] a_in, b_in;
  logic [1:0]  a_i, a_j, b_i, b_j;
  logic        a_we, b_we, mm_start, busy, batch_done;
  logic        mm_done = 1'b1;

  matrix_stream_loader #(.N(4), .N_LEN(2)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .a_in(a_in), .a_i(a_i), .a_j(a_j), .a_we(a_we),
    .b_in(b_in), .b_i(b_i), .b_j(b_j), .b_we(b_we),
    .mm_start(mm_start), .mm_done(mm_done), .busy(busy), .batch_done(batch_done)
  );

  // N=10 instance
  logic [31:0] in_data10 = '0;
  logic        in_valid10 = 1'b0, in_ready10;
  logic [31:0] a_in10, b_in10;
  logic [3:0]  a_i10, a_j10, b_i10, b_j10;
  logic        a_we10, b_we10, mm_start10, busy10, batch_done10;
  logic        mm_done10 = 1'b0;

  matrix_stream_loader #(.N(10), .N_LEN(4)) dut10 (
    .clk(clk), .rst(rst), .in_data(in_data10), .in_valid(in_valid10), .in_ready(in_ready10),
    .a_in(a_in10), .a_i(a_i10), .a_j(a_j10), .a_we(a_we10),
    .b_in(b_in10), .b_i(b_i10), .b_j(b_j10), .b_we(b_we10),
    .mm_start(mm_start10), .mm_done(mm_done10), .busy(busy10), .batch_done(batch_done10)
  );

  int   n_checks = 0;
  int   n_fail = 0;
  exp_t q4[$];
  exp_t q10[$];
  int   k4 = 0, k10 = 0;
  int   cyc = 0, last_strobe_cyc = -10;
  int   start_cnt = 0, done_cnt = 0, start10_cnt = 0, done10_cnt = 0;
  int   t0_10 = -1, tstart10 = -1;
  int   mx_idx10 = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic pop_cmp(input int which, input string name, input exp_t act);
    exp_t e;
    if ((which == 0 && q4.size() == 0) || (which != 0 && q10.size() == 0)) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: unexpected strobe 0x%0h, expected none", name, act);
    end else begin
      if (which == 0) e = q4.pop_front();
      else            e = q10.pop_front();
      chk(name, act, e);
    end
  endtask

  // Monitor, N=4
  logic        a_we_p = 1'b0, b_we_p = 1'b0;
  logic [35:0] a_p = '0, b_p = '0;
  always @(negedge clk) begin
    exp_t act;
    cyc++;
    if (a_we && !a_we_p) begin
      chk("a_hold_before_we", {a_i, a_j, a_in}, a_p);
      act = {1'b0, 2'b00, a_i, 2'b00, a_j, a_in};
      pop_cmp(0, "a_elem", act);
      last_strobe_cyc = cyc;
    end
    if (b_we && !b_we_p) begin
      chk("b_hold_before_we", {b_i, b_j, b_in}, b_p);
      act = {1'b1, 2'b00, b_i, 2'b00, b_j, b_in};
      pop_cmp(0, "b_elem", act);
      last_strobe_cyc = cyc;
    end
    if (mm_start) begin
      chk("start_after_last_strobe", cyc, last_strobe_cyc + 1);
      chk("start_queue_empty", q4.size(), 0);
      start_cnt++;
    end
    if (batch_done) done_cnt++;
    a_we_p = a_we;
    b_we_p = b_we;
    a_p = {a_i, a_j, a_in};
    b_p = {b_i, b_j, b_in};
  end

  // Monitor, N=10
  logic a_we10_p = 1'b0, b_we10_p = 1'b0;
  always @(negedge clk) begin
    exp_t act;
    if (in_valid10 && in_ready10 && t0_10 < 0) t0_10 = cyc;
    if (a_we10 && !a_we10_p) begin
      act = {1'b0, a_i10, a_j10, a_in10};
      pop_cmp(1, "a10_elem", act);
      if (int'(a_i10) > mx_idx10) mx_idx10 = int'(a_i10);
      if (int'(a_j10) > mx_idx10) mx_idx10 = int'(a_j10);
    end
    if (b_we10 && !b_we10_p) begin
      act = {1'b1, b_i10, b_j10, b_in10};
      pop_cmp(1, "b10_elem", act);
      if (int'(b_i10) > mx_idx10) mx_idx10 = int'(b_i10);
      if (int'(b_j10) > mx_idx10) mx_idx10 = int'(b_j10);
    end
    if (mm_start10) begin
      tstart10 = cyc;
      start10_cnt++;
    end
    if (batch_done10) done10_cnt++;
    a_we10_p = a_we10;
    b_we10_p = b_we10;
  end

  // Drive one word to the N=4 loader; push the element write it must produce.
  task automatic send4(input logic [31:0] d);
    int w = 0;
    exp_t e;
    in_valid = 1'b1;
    in_data  = d;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      if (++w > 50) begin
        chk("send4_ready_timeout", 0, 1);
        break;
      end
    end
    e.sel = (k4 >= 16);
    e.i   = 4'((k4 % 16) / 4);
    e.j   = 4'(k4 % 4);
    e.d   = d;
    q4.push_back(e);
    k4++;
    @(posedge clk);
    #1;
  endtask

  task automatic send10(input logic [31:0] d);
    int w = 0;
    exp_t e;
    in_valid10 = 1'b1;
    in_data10  = d;
    forever begin
      @(negedge clk);
      if (in_ready10) break;
      if (++w > 50) begin
        chk("send10_ready_timeout", 0, 1);
        break;
      end
    end
    e.sel = (k10 >= 100);
    e.i   = 4'((k10 % 100) / 10);
    e.j   = 4'(k10 % 10);
    e.d   = d;
    q10.push_back(e);
    k10++;
    @(posedge clk);
    #1;
  endtask

  // Wait for start with mm_done stale high, then complete the handshake.
  task automatic finish4(input string tag);
    int w = 0;
    while (start_cnt == 0 && w < 20) begin
      @(negedge clk);
      w++;
    end
    repeat (8) @(negedge clk);
    chk({tag, "_no_done_stale"}, done_cnt, 0);
    chk({tag, "_ready_low_wait"}, in_ready, 0);
    chk({tag, "_busy_wait"}, busy, 1);
    @(posedge clk); #1 mm_done = 1'b0;
    repeat (5) @(posedge clk);
    #1 mm_done = 1'b1;
    @(negedge clk);
    chk({tag, "_done_not_early"}, batch_done, 0);
    @(negedge clk);
    chk({tag, "_done_pulse"}, batch_done, 1);
    chk({tag, "_busy_fall"}, busy, 0);
    @(negedge clk);
    chk({tag, "_done_one_cycle"}, batch_done, 0);
    chk({tag, "_ready_after"}, in_ready, 1);
    chk({tag, "_done_count"}, done_cnt, 1);
    chk({tag, "_start_count"}, start_cnt, 1);
    chk({tag, "_all_strobed"}, q4.size(), 0);
    start_cnt = 0;
    done_cnt  = 0;
    k4        = 0;
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_strobes", {a_we, b_we, mm_start, busy, batch_done}, 0);
    chk("rst_a_port", {a_in, a_i, a_j}, 0);
    chk("rst_b_port", {b_in, b_i, b_j}, 0);
    @(posedge clk); #1 rst = 1'b1;

    // Batch 1: words 1..32 back to back, mm_done stale high
    for (int k = 1; k <= 32; k++) send4(32'(k));
    in_valid = 1'b0;
    finish4("b1");

    // Batch 2: back-to-back reload with bubbles
    for (int k = 0; k < 32; k++) begin
      send4(32'hA000_0000 + 32'(k));
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
    end
    finish4("b2");

    // Abort after word 20 (B[0][3] accepted, strobe pending)
    for (int k = 1; k <= 20; k++) send4(32'h5000 + 32'(k));
    in_valid = 1'b0;
    rst = 1'b0;
    q4.delete();
    k4 = 0;
    start_cnt = 0;
    @(negedge clk);
    chk("abort_strobes", {a_we, b_we, mm_start}, 0);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_busy", busy, 0);
    @(posedge clk); #1 rst = 1'b1;
    for (int k = 1; k <= 32; k++) send4(32'hC000 + 32'(k));
    in_valid = 1'b0;
    finish4("b3");

    // N=10, 200 words
    for (int k = 0; k < 200; k++) send10(32'h1000 + 32'(k));
    in_valid10 = 1'b0;
    for (int w = 0; w < 20 && start10_cnt == 0; w++) @(negedge clk);
    chk("n10_start_count", start10_cnt, 1);
    chk("n10_load_ge_400", (tstart10 - t0_10) >= 400, 1);
    chk("n10_max_index", mx_idx10, 9);
    chk("n10_all_strobed", q10.size(), 0);
    repeat (3) @(posedge clk);
    #1 mm_done10 = 1'b1;
    repeat (3) @(negedge clk);
    chk("n10_done_count", done10_cnt, 1);
    chk("n10_busy_fall", busy10, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
